// File: rtl/mem_req_initiator.sv
// mem_req_initiator
//
// Traffic generator for a simple memory request port. A run writes
// num_txn_i pseudo-random (address, data) pairs, records each pair in a
// small local table, then reads every address back in the same order. Each
// read is compared against the recorded data and mismatches are counted.
// There is a one-cycle gap after every accepted request and a one-cycle
// done pulse at the end of the run.
//
// Handshake: a request is presented when req_o=1. req_rnw_o, req_addr_o and
// req_wdata_o hold steady until a rising edge with req_ready_i=1, which is
// the transfer edge. For reads, req_rdata_i is valid in that same cycle.
// req_ready_i is ignored while req_o=0.
//
// Ports
//   clk          clock, all state on rising edge
//   reset        asynchronous active-low reset
//   start_i      run command, sampled in IDLE only
//   num_txn_i    transactions per run, clamped to TXN_MAX
//   seed_i       address LFSR seed (0 is replaced by 1)
//   req_o        request valid
//   req_rnw_o    1 = read, 0 = write
//   req_addr_o   request address
//   req_wdata_o  write data (0 during reads)
//   req_ready_i  responder accept
//   req_rdata_i  read data, sampled on read transfer edges
//   busy_o       run in progress (WR, WGAP, RD, RGAP)
//   done_o       one-cycle pulse at run end
//   err_cnt_o    readback mismatches in the last run
//
// The address LFSR taps (x^10+x^7+1) assume ADDR_W = 10. TXN_MAX must be
// at least 2 and no more than 31.
module mem_req_initiator #(
  parameter int TXN_MAX = 16,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [4:0]        num_txn_i,
  input  logic [ADDR_W-1:0] seed_i,
  output logic              req_o,
  output logic              req_rnw_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [DATA_W-1:0] req_wdata_o,
  input  logic              req_ready_i,
  input  logic [DATA_W-1:0] req_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [4:0]        err_cnt_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_WGAP = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_RGAP = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int              TBL_AW    = (TXN_MAX > 1) ? $clog2(TXN_MAX) : 1;
  localparam logic [4:0]      TXN_MAX_C = 5'(TXN_MAX);
  localparam logic [DATA_W-1:0] DATA_SEED = DATA_W'(32'hACE10001);

  logic [2:0]        state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic [4:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_lfsr_q, addr_lfsr_d;
  logic [DATA_W-1:0] data_lfsr_q, data_lfsr_d;
  logic [4:0]        err_cnt_q, err_cnt_d;

  // Record of what was written; read back in the same order.
  logic [ADDR_W-1:0] tbl_addr [TXN_MAX];
  logic [DATA_W-1:0] tbl_data [TXN_MAX];

  logic [TBL_AW-1:0] tbl_idx;
  logic [4:0]        num_clamped;
  logic [ADDR_W-1:0] seed_fixed;
  logic [ADDR_W-1:0] addr_lfsr_nxt;
  logic [DATA_W-1:0] data_lfsr_nxt;

  // The index never reaches TXN_MAX while a request is being presented, so
  // the low bits address the table directly.
  assign tbl_idx     = idx_q[TBL_AW-1:0];
  assign num_clamped = (num_txn_i > TXN_MAX_C) ? TXN_MAX_C : num_txn_i;
  // An all-zero seed would lock the LFSR at zero.
  assign seed_fixed  = (seed_i == '0) ? ADDR_W'(1) : seed_i;

  // Fibonacci LFSRs shifting left, feedback into bit 0.
  // Address: x^10 + x^7 + 1 -> taps at bits 9 and 6.
  // Data:    x^32 + x^22 + x^2 + x + 1 -> taps at bits 31, 21, 1 and 0.
  assign addr_lfsr_nxt = {addr_lfsr_q[ADDR_W-2:0], addr_lfsr_q[9] ^ addr_lfsr_q[6]};
  assign data_lfsr_nxt = {data_lfsr_q[DATA_W-2:0],
                          data_lfsr_q[31] ^ data_lfsr_q[21] ^ data_lfsr_q[1] ^ data_lfsr_q[0]};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    addr_lfsr_d = addr_lfsr_q;
    data_lfsr_d = data_lfsr_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          count_d     = num_clamped;
          addr_lfsr_d = seed_fixed;
          data_lfsr_d = DATA_SEED;
          err_cnt_d   = 5'd0;
          idx_d       = 5'd0;
          state_d     = (num_clamped == 5'd0) ? S_DONE : S_WR;
        end
      end
      S_WR: begin
        if (req_ready_i) begin
          addr_lfsr_d = addr_lfsr_nxt;
          data_lfsr_d = data_lfsr_nxt;
          idx_d       = idx_q + 5'd1;
          state_d     = S_WGAP;
        end
      end
      S_WGAP: begin
        if (idx_q < count_q) begin
          state_d = S_WR;
        end else begin
          idx_d   = 5'd0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (req_ready_i) begin
          // err_cnt cannot exceed count (<= TXN_MAX), so no saturation needed.
          if (req_rdata_i != tbl_data[tbl_idx]) begin
            err_cnt_d = err_cnt_q + 5'd1;
          end
          idx_d   = idx_q + 5'd1;
          state_d = S_RGAP;
        end
      end
      S_RGAP: begin
        state_d = (idx_q < count_q) ? S_RD : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      count_q     <= 5'd0;
      idx_q       <= 5'd0;
      addr_lfsr_q <= ADDR_W'(1);
      data_lfsr_q <= DATA_SEED;
      err_cnt_q   <= 5'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      addr_lfsr_q <= addr_lfsr_d;
      data_lfsr_q <= data_lfsr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Table storage is plain RAM-style: no reset, written on write transfers.
  always_ff @(posedge clk) begin
    if ((state_q == S_WR) && req_ready_i) begin
      tbl_addr[tbl_idx] <= addr_lfsr_q;
      tbl_data[tbl_idx] <= data_lfsr_q;
    end
  end

  // All outputs decode from registered state only, so the asynchronous
  // reset clears them without waiting for a clock edge.
  always_comb begin
    req_o       = 1'b0;
    req_rnw_o   = 1'b0;
    req_addr_o  = '0;
    req_wdata_o = '0;
    case (state_q)
      S_WR: begin
        req_o       = 1'b1;
        req_addr_o  = addr_lfsr_q;
        req_wdata_o = data_lfsr_q;
      end
      S_RD: begin
        req_o      = 1'b1;
        req_rnw_o  = 1'b1;
        req_addr_o = tbl_addr[tbl_idx];
      end
      default: begin
        req_o = 1'b0;
      end
    endcase
  end

  assign busy_o    = (state_q == S_WR) || (state_q == S_WGAP) ||
                     (state_q == S_RD) || (state_q == S_RGAP);
  assign done_o    = (state_q == S_DONE);
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_mem_req_initiator.sv
// tb_mem_req_initiator
//
// Directed sequence of runs against mem_req_initiator with a behavioural
// memory responder. Expected addresses and data come from the LFSR
// polynomials evaluated in a generic polynomial-step function; expected
// mismatch counts come from comparing what the responder returns with what
// the model says was written.
module tb_mem_req_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [4:0]  num_txn_i;
  logic [9:0]  seed_i;
  logic        req_o;
  logic        req_rnw_o;
  logic [9:0]  req_addr_o;
  logic [31:0] req_wdata_o;
  logic        req_ready_i;
  logic [31:0] req_rdata_i;
  logic        busy_o;
  logic        done_o;
  logic [4:0]  err_cnt_o;

  int total = 0;
  int bad   = 0;
  int last_err = 0;

  logic [31:0] mem  [0:1023];
  bit          seen [0:1023];
  logic [9:0]  exp_addr_q [$];
  logic [31:0] exp_q      [$];

  mem_req_initiator #(.TXN_MAX(16), .ADDR_W(10), .DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .num_txn_i   (num_txn_i),
    .seed_i      (seed_i),
    .req_o       (req_o),
    .req_rnw_o   (req_rnw_o),
    .req_addr_o  (req_addr_o),
    .req_wdata_o (req_wdata_o),
    .req_ready_i (req_ready_i),
    .req_rdata_i (req_rdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One step of a Fibonacci LFSR of width w for the polynomial
  // x^w + x^t0 + x^t1 + x^t2 + 1 (a zero exponent means the term is absent).
  function automatic logic [31:0] poly_step(input logic [31:0] v, input int w,
                                            input int t0, input int t1, input int t2);
    logic        fb;
    logic [31:0] m;
    fb = v[w-1];
    if (t0 > 0) fb = fb ^ v[t0-1];
    if (t1 > 0) fb = fb ^ v[t1-1];
    if (t2 > 0) fb = fb ^ v[t2-1];
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return ((v << 1) | {31'd0, fb}) & m;
  endfunction

  // One complete run. Entry: at a negedge before the IDLE cycle that will
  // sample start. Exit: at the negedge where done_o is seen.
  task automatic run(input int n, input logic [9:0] seed, input int max_wait,
                     input bit tie, input int c0, input int c1, input bit hold);
    int          exp_n, cyc, wr_n, rd_n, wl, exp_err, idx;
    bit          pend, after_hs, gap, fin, exp_rnw;
    logic        s_rnw;
    logic [9:0]  s_addr;
    logic [31:0] s_wdata, a, d, flip;

    exp_n = (n > 16) ? 16 : n;
    exp_addr_q.delete();
    exp_q.delete();
    a = (seed == 10'd0) ? 32'd1 : {22'd0, seed};
    d = 32'hACE10001;
    for (int i = 0; i < exp_n; i++) begin
      exp_addr_q.push_back(a[9:0]);
      exp_q.push_back(d);
      a = poly_step(a, 10, 7, 0, 0);
      d = poly_step(d, 32, 22, 2, 1);
    end
    for (int i = 0; i < 1024; i++) seen[i] = 1'b0;

    @(negedge clk);
    check("idle_req", {31'd0, req_o}, 32'd0);
    check("idle_busy", {31'd0, busy_o}, 32'd0);
    check("done_pulse_len", {31'd0, done_o}, 32'd0);
    check("err_hold", {27'd0, err_cnt_o}, last_err);
    start_i     = 1'b1;
    num_txn_i   = 5'(n);
    seed_i      = seed;
    req_ready_i = 1'b0;

    cyc = 0; wr_n = 0; rd_n = 0; wl = 0; exp_err = 0;
    pend = 0; after_hs = 0; gap = 0; fin = 0;
    s_rnw = 0; s_addr = 0; s_wdata = 0; exp_rnw = 0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("first_req", {31'd0, req_o}, (exp_n > 0) ? 32'd1 : 32'd0);
      if (after_hs) begin
        check("gap_req", {31'd0, req_o}, 32'd0);
        check("gap_busy", {31'd0, busy_o}, 32'd1);
        after_hs = 0;
        gap = 1;
      end else if (gap) begin
        gap = 0;
        if (wr_n + rd_n < 2 * exp_n) check("req_after_gap", {31'd0, req_o}, 32'd1);
        else check("done_after_gap", {31'd0, done_o}, 32'd1);
      end

      if (done_o) begin
        if (max_wait == 0) check("latency", cyc, 4 * exp_n + 1);
        check("writes", wr_n, exp_n);
        check("reads", rd_n, exp_n);
        check("err_cnt", {27'd0, err_cnt_o}, exp_err);
        check("done_busy", {31'd0, busy_o}, 32'd0);
        check("done_req", {31'd0, req_o}, 32'd0);
        last_err    = exp_err;
        start_i     = hold;
        req_ready_i = tie;
        fin = 1;
      end else if (cyc > 2000) begin
        check("done_timeout", {31'd0, done_o}, 32'd1);
        start_i = 1'b0;
        fin = 1;
      end else begin
        check("busy", {31'd0, busy_o}, 32'd1);
        if (!hold) start_i = 1'($urandom_range(0, 1));
        if (req_o) begin
          if (wr_n + rd_n >= 2 * exp_n) begin
            check("extra_req", {31'd0, req_o}, 32'd0);
            req_ready_i = 1'b1;
          end else begin
            if (pend) begin
              check("hold_rnw", {31'd0, req_rnw_o}, {31'd0, s_rnw});
              check("hold_addr", {22'd0, req_addr_o}, {22'd0, s_addr});
              check("hold_wdata", req_wdata_o, s_wdata);
            end else begin
              exp_rnw = (wr_n >= exp_n);
              idx     = exp_rnw ? rd_n : wr_n;
              check("rnw", {31'd0, req_rnw_o}, {31'd0, exp_rnw});
              check("addr", {22'd0, req_addr_o}, {22'd0, exp_addr_q[idx]});
              check("wdata", req_wdata_o, exp_rnw ? 32'd0 : exp_q[idx]);
              s_rnw = req_rnw_o; s_addr = req_addr_o; s_wdata = req_wdata_o;
              pend = 1;
              wl = $urandom_range(0, max_wait);
            end
            if (wl == 0) begin
              req_ready_i = 1'b1;
              pend = 0;
              after_hs = 1;
              if (wr_n < exp_n) begin
                check("addr_distinct", {31'd0, seen[req_addr_o]}, 32'd0);
                seen[req_addr_o] = 1'b1;
                mem[req_addr_o]  = req_wdata_o;
                wr_n++;
              end else begin
                flip = (rd_n == c0 || rd_n == c1) ? 32'd1 : 32'd0;
                req_rdata_i = mem[req_addr_o] ^ flip;
                if (req_rdata_i !== exp_q[rd_n]) exp_err++;
                rd_n++;
              end
            end else begin
              req_ready_i = 1'b0;
              req_rdata_i = $urandom;
              wl--;
            end
          end
        end else begin
          // Ready and data while no request is presented must be ignored.
          req_ready_i = tie ? 1'b1 : 1'($urandom_range(0, 1));
          req_rdata_i = $urandom;
        end
      end
    end
  endtask

  initial begin
    int k;
    reset       = 1'b0;
    start_i     = 1'b0;
    num_txn_i   = 5'd0;
    seed_i      = 10'd0;
    req_ready_i = 1'b0;
    req_rdata_i = 32'd0;

    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, req_o}, 32'd0);
    check("rst_rnw", {31'd0, req_rnw_o}, 32'd0);
    check("rst_addr", {22'd0, req_addr_o}, 32'd0);
    check("rst_wdata", req_wdata_o, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_err", {27'd0, err_cnt_o}, 32'd0);
    reset = 1'b1;

    // Ideal responder, ready tied high.
    run(10, 10'h155, 0, 1'b1, -1, -1, 1'b0);
    // Random latency responder, full-size run.
    run(16, 10'($urandom), 5, 1'b0, -1, -1, 1'b0);
    // Corrupted read data on transactions 3 and 7.
    run(10, 10'($urandom), 2, 1'b0, 3, 7, 1'b0);
    // Empty run and clamped run.
    run(0, 10'h2AB, 0, 1'b1, -1, -1, 1'b0);
    run(20, 10'($urandom), 0, 1'b1, -1, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run($urandom_range(1, 20), 10'($urandom), $urandom_range(0, 3), 1'b0, -1, -1, 1'b0);
    end

    // Reset in the read phase while the responder stalls.
    @(negedge clk);
    start_i = 1'b1; num_txn_i = 5'd4; seed_i = 10'h03C; req_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    k = 0;
    while (!(req_o && req_rnw_o) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("rd_phase_reached", {31'd0, req_rnw_o}, 32'd1);
    req_ready_i = 1'b0;
    @(negedge clk);
    check("rd_stall_req", {31'd0, req_o}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_req", {31'd0, req_o}, 32'd0);
    check("async_rnw", {31'd0, req_rnw_o}, 32'd0);
    check("async_addr", {22'd0, req_addr_o}, 32'd0);
    check("async_busy", {31'd0, busy_o}, 32'd0);
    check("async_err", {27'd0, err_cnt_o}, 32'd0);
    check("async_done", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_done", {31'd0, done_o}, 32'd0);
      check("post_rst_busy", {31'd0, busy_o}, 32'd0);
    end
    last_err = 0;
    // Seed 0 must behave as seed 1.
    run(5, 10'd0, 3, 1'b0, -1, -1, 1'b0);

    // start held high: back-to-back runs, start ignored while busy.
    run(3, 10'($urandom), 0, 1'b1, -1, -1, 1'b1);
    run(4, 10'($urandom), 0, 1'b1, -1, -1, 1'b1);
    run(3, 10'($urandom), 2, 1'b0, -1, -1, 1'b0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
